fetch_dispatch_ctrl: RTL
========================

# fetch_dispatch_ctrl

Instruction fetch and dispatch controller for the microcontroller datapath, sitting directly upstream of the memory load/store controller. It fetches the word at PC over the shared bus into an instruction register and decodes the opcode. It presents the instruction word to the execution units and holds it stable until the selected unit returns `done`. It then zeroes the presented word so the load/store controller falls back to its idle state, and it retires the instruction.

## Interface
- `DONE_TIMEOUT`, 31: maximum cycles spent in EXEC_WAIT before faulting; range 1–255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; permits fetch of a new instruction.
- `bus_in`  in  16  shared data bus, sampled in F_IR.
- `ls_done`  in  1  one-cycle done pulse from the load/store controller.
- `alu_done`  in  1  one-cycle done pulse from the ALU sequencer.
- `PC_out`  out  1  PC drives the bus.
- `PC_inc`  out  1  PC increment strobe (ALU ops only).
- `MAR_EN`  out  1  MAR load.
- `mem_EN`  out  1  memory enable.
- `mem_RW`  out  1  1 = read.
- `MDR_EN_read`  out  1  MDR loads from memory.
- `MDR_out`  out  1  MDR drives the bus.
- `IR_in`  out  1  IR loads from the bus.
- `fullBitNum`  out  16  presented instruction word, or 16'h0000 outside DECODE/EXEC_WAIT.
- `alu_go`  out  1  one-cycle ALU start pulse.
- `instr_count`  out  16  retired-instruction counter, wraps.
- `halted`  out  1  sticky; set on HALT opcode.
- `fault`  out  1  sticky; set on illegal opcode or timeout.

## Operation
- Opcode is IR[15:12].
  - LOAD = 4'b0011 and STORE = 4'b0100 go to the LS class.
  - 4'b0001, 4'b0010, 4'b0101 and 4'b0110 go to the ALU class.
  - HALT = 4'b1111.
  - All other opcodes are illegal.
- States and transitions:
  - IDLE → F_ADDR when `run`=1.
  - F_ADDR (`PC_out`, `MAR_EN`) → F_READ.
  - F_READ (`mem_EN`, `mem_RW`) → F_LATCH.
  - F_LATCH (`mem_EN`, `mem_RW`, `MDR_EN_read`) → F_IR.
  - F_IR (`MDR_out`, `IR_in`; IR ← `bus_in`) → DECODE.
  - DECODE:
    - LS: → EXEC_WAIT.
    - ALU: `alu_go`=1 and `PC_inc`=1, → EXEC_WAIT.
    - HALT: → HALTED.
    - Illegal: → FAULT.
  - EXEC_WAIT: wait for the done of the dispatched class.
    - On that done: `instr_count`+1, then → F_ADDR if `run`, else → IDLE.
    - On timeout: → FAULT.
  - HALTED and FAULT are absorbing until `rst`.
- `fullBitNum` equals IR only in DECODE and EXEC_WAIT. It is 16'h0000 in every other state, including the cycle after retire, which releases the load/store controller's terminal state.
- Done from the non-dispatched unit is ignored. Done is sampled only in EXEC_WAIT.
- The LS class does not pulse `PC_inc`; the load/store controller increments PC itself.
- Watchdog:
  - The counter clears on entry to EXEC_WAIT and increments each cycle without a matching done.
  - Fault fires when the count reaches `DONE_TIMEOUT` with no done.
  - If done arrives in the same cycle the count reaches `DONE_TIMEOUT`, done wins.
- `run` deasserted mid-instruction: the current instruction completes and retires, then the block enters IDLE.
- `instr_count` wraps 16'hFFFF → 16'h0000. HALT and illegal opcodes are not counted.

## Timing
- Reset (synchronous):
  - State = IDLE, IR = 0, `instr_count` = 0.
  - All outputs = 0, including `fullBitNum`, `halted` and `fault`.
  - `rst` mid-instruction aborts the instruction; `fullBitNum` = 0 on the next cycle.
- Control outputs are combinational from the registered state and IR, and are glitch-free per state.
- Fetch latency: 4 cycles (F_ADDR → F_IR), then 1 DECODE cycle. `fullBitNum` is valid from the DECODE cycle.
- Retire: done seen at edge N → `fullBitNum` = 0 and state F_ADDR/IDLE from cycle N+1.
- Minimum ALU instruction: 6 cycles (done in the first EXEC_WAIT cycle).

## Structure
- Shared package `mc_pkg`:
  - Opcode constants (OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_HALT).
  - State enumeration for this block.
  - 16-bit instruction width constant.
- One sub-module, `exec_watchdog`: an 8-bit counter with inputs clear, count enable and `DONE_TIMEOUT`, and a `timeout` output.

## Test plan
- Reset, then `run`=1 with `bus_in`=16'h3080 (LOAD into G1) and `ls_done` 6 cycles after DECODE → strobes follow the state order above, `fullBitNum`=16'h3080 for 7 cycles, then 0; `instr_count`=1; no `PC_inc`.
- `bus_in`=16'h1042 (ALU), `alu_done` in the first EXEC_WAIT cycle → `alu_go` and `PC_inc` one-cycle pulses in DECODE; retire 6 cycles after fetch start; next F_ADDR immediately.
- `bus_in`=16'h4003 (STORE), `alu_done` pulsed before `ls_done` → ALU done ignored; retire only on `ls_done`.
- `bus_in`=16'h3000, no done for 31 cycles → `fault`=1 and `fullBitNum`=0 at cycle 32; `run` toggling has no effect until `rst`.
- `bus_in`=16'h7000 → `fault`=1 after DECODE. `bus_in`=16'hF000 → `halted`=1; `instr_count` unchanged in both cases.
- `run` dropped during EXEC_WAIT → retire then IDLE. Preload `instr_count`=16'hFFFF by 65535 retires (or force) → wraps to 0. `rst` asserted in F_READ → all outputs 0 next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the microcontroller datapath: instruction width,
// opcode constants, the fetch/dispatch state set and opcode classification.
package mc_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_F_ADDR    = 4'd1,
        ST_F_READ    = 4'd2,
        ST_F_LATCH   = 4'd3,
        ST_F_IR      = 4'd4,
        ST_DECODE    = 4'd5,
        ST_EXEC_WAIT = 4'd6,
        ST_HALTED    = 4'd7,
        ST_FAULT     = 4'd8
    } fd_state_e;

    typedef enum logic [1:0] {
        CLS_LS      = 2'd0,
        CLS_ALU     = 2'd1,
        CLS_HALT    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

    // Map an opcode to the execution unit that will return its done.
    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_LOAD, OP_STORE:               cls = CLS_LS;
            OP_ADD, OP_SUB, OP_AND, OP_OR:   cls = CLS_ALU;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Counts EXEC_WAIT cycles that pass without the dispatched unit's done.
// timeout is asserted in the cycle whose missing done brings the count to
// done_timeout, so the controller can fault on that same edge.
module exec_watchdog (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       count_en,
    input  logic [7:0] done_timeout,
    output logic       timeout
);

    logic [7:0] count_q;

    // Wait counter: cleared on entry to EXEC_WAIT, saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= 8'd0;
        end else if (count_en && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign timeout = count_en && (({1'b0, count_q} + 9'd1) >= {1'b0, done_timeout});

endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// Instruction fetch and dispatch controller. Fetches the word at PC over the
// shared bus into IR, decodes the opcode, presents the word to the execution
// units until the dispatched unit returns done, then retires it.
// Outputs are Moore-style decodes of the registered state and IR.
module fetch_dispatch_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned DONE_TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] bus_in,
    input  logic        ls_done,
    input  logic        alu_done,
    output logic        PC_out,
    output logic        PC_inc,
    output logic        MAR_EN,
    output logic        mem_EN,
    output logic        mem_RW,
    output logic        MDR_EN_read,
    output logic        MDR_out,
    output logic        IR_in,
    output logic [15:0] fullBitNum,
    output logic        alu_go,
    output logic [15:0] instr_count,
    output logic        halted,
    output logic        fault,
    output logic [3:0]  state_dbg
);

    fd_state_e            state_q;
    fd_state_e            state_d;
    logic [INSTR_W-1:0]   ir_q;
    logic [15:0]          count_q;
    op_class_e            cls;
    logic                 done_hit;
    logic                 retire;
    logic                 wd_clear;
    logic                 wd_en;
    logic                 wd_timeout;

    assign cls = op_class(ir_q[15:12]);

    // Only the done of the unit that owns the current instruction counts.
    assign done_hit = ((cls == CLS_LS)  && ls_done) ||
                      ((cls == CLS_ALU) && alu_done);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register, loaded from the bus in F_IR.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= '0;
        end else if (state_q == ST_F_IR) begin
            ir_q <= bus_in;
        end
    end

    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'd0;
        end else if (retire) begin
            count_q <= count_q + 16'd1;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_d     = state_q;
        PC_out      = 1'b0;
        PC_inc      = 1'b0;
        MAR_EN      = 1'b0;
        mem_EN      = 1'b0;
        mem_RW      = 1'b0;
        MDR_EN_read = 1'b0;
        MDR_out     = 1'b0;
        IR_in       = 1'b0;
        alu_go      = 1'b0;
        retire      = 1'b0;
        wd_clear    = 1'b0;
        wd_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_F_ADDR;
            end
            ST_F_ADDR: begin
                PC_out  = 1'b1;
                MAR_EN  = 1'b1;
                state_d = ST_F_READ;
            end
            ST_F_READ: begin
                mem_EN  = 1'b1;
                mem_RW  = 1'b1;
                state_d = ST_F_LATCH;
            end
            ST_F_LATCH: begin
                mem_EN      = 1'b1;
                mem_RW      = 1'b1;
                MDR_EN_read = 1'b1;
                state_d     = ST_F_IR;
            end
            ST_F_IR: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                wd_clear = 1'b1;
                case (cls)
                    CLS_LS: begin
                        state_d = ST_EXEC_WAIT;
                    end
                    CLS_ALU: begin
                        alu_go  = 1'b1;
                        PC_inc  = 1'b1;
                        state_d = ST_EXEC_WAIT;
                    end
                    CLS_HALT: begin
                        state_d = ST_HALTED;
                    end
                    default: begin
                        state_d = ST_FAULT;
                    end
                endcase
            end
            ST_EXEC_WAIT: begin
                // A done in the limit cycle still retires: done is checked first.
                if (done_hit) begin
                    retire  = 1'b1;
                    state_d = run ? ST_F_ADDR : ST_IDLE;
                end else begin
                    wd_en = 1'b1;
                    if (wd_timeout) state_d = ST_FAULT;
                end
            end
            ST_HALTED, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    exec_watchdog u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .clear        (wd_clear),
        .count_en     (wd_en),
        .done_timeout (8'(DONE_TIMEOUT)),
        .timeout      (wd_timeout)
    );

    // The word is only presented while an instruction is in flight; zero
    // elsewhere releases the load/store controller's terminal state.
    assign fullBitNum  = ((state_q == ST_DECODE) || (state_q == ST_EXEC_WAIT)) ? ir_q : 16'h0000;
    assign instr_count = count_q;
    assign halted      = (state_q == ST_HALTED);
    assign fault       = (state_q == ST_FAULT);
    assign state_dbg   = state_q;

endmodule
